// File: rtl/uart_tx_device_pkg.sv
// uart_tx_device_pkg: shared addresses, CTRL bit positions and tx FSM encoding.
// Optional parity build controlled by `UART_TX_PARITY_EN.
package uart_tx_device_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  localparam logic [31:0] UART_DATA_BASE = 32'hF0000030;
  localparam logic [31:0] UART_CTRL_BASE = 32'hF0000130;
  localparam int CTRL_READY = 0;
  localparam int CTRL_BUSY = 1;
  localparam int CTRL_OVERRUN = 2;
  localparam int CTRL_PARITY = 3;
`ifdef UART_TX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif
endpackage

// File: rtl/uart_tx_device_if.sv
// uart_tx_device_if: processor bus slice seen by the UART (strobes, address, data in/out).
interface uart_tx_device_if #(parameter int BITS = 32);
  logic we;
  logic re;
  logic [BITS-1:0] memAddr;
  logic [BITS-1:0] dataBusIn;
  logic [BITS-1:0] dataBusOut;
  modport master(output we, re, memAddr, dataBusIn, input dataBusOut);
  modport slave(input we, re, memAddr, dataBusIn, output dataBusOut);
endinterface

// File: rtl/uart_tx_device_sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count; a push into a full FIFO is accepted when a pop happens the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/uart_tx_device.sv
// uart_tx_device: memory-mapped UART transmitter (8N1, LSB first) with tx FIFO and CTRL/status register.
// Define `UART_TX_PARITY_EN for an even-parity bit between data and stop (CTRL[3] reads 1).
module uart_tx_device
  import uart_tx_device_pkg::*;
#(
  parameter int BITS = 32,
  parameter logic [BITS-1:0] BASE = BITS'(UART_DATA_BASE),
  parameter logic [BITS-1:0] CTRL_BASE = BITS'(UART_CTRL_BASE),
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_device_if.slave   bus,
  output logic              txd
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  tx_state_t state, nxt;
  logic [CW-1:0] count;
  logic [7:0] fifo_out, shift;
  logic [2:0] bit_cnt;
  logic [BW-1:0] baud;
  logic full, empty, pop, wrap, wr_data, wr_ctrl, overrun, busy;
  logic [BITS-1:0] ctrl;
  logic unused;
  assign unused = ^{bus.re, bus.dataBusIn[BITS-1:8]};
  assign wr_data = bus.we && bus.memAddr == BASE;
  assign wr_ctrl = bus.we && bus.memAddr == CTRL_BASE;
  assign wrap = baud == BW'(CLKS_PER_BIT - 1);
  assign pop = !empty && (state == IDLE || (state == STOP && wrap));
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) fifo (
    .clk(clk),
    .reset(reset),
    .push(wr_data),
    .pop(pop),
    .din(bus.dataBusIn[7:0]),
    .dout(fifo_out),
    .full(full),
    .empty(empty),
    .count(count)
  );
  // Overrun only when the FIFO really rejects the byte (full and no pop this edge).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) overrun <= 1'b0;
    else if (wr_data && full && !pop) overrun <= 1'b1;
    else if (wr_ctrl && !bus.dataBusIn[CTRL_OVERRUN]) overrun <= 1'b0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:   nxt = pop ? START : IDLE;
      START:  nxt = wrap ? DATA : START;
`ifdef UART_TX_PARITY_EN
      DATA:   nxt = (wrap && bit_cnt == 3'd7) ? PARITY : DATA;
`else
      DATA:   nxt = (wrap && bit_cnt == 3'd7) ? STOP : DATA;
`endif
      PARITY: nxt = wrap ? STOP : PARITY;
      STOP:   nxt = wrap ? (pop ? START : IDLE) : STOP;
      default: nxt = IDLE;
    endcase
  end
`ifdef UART_TX_PARITY_EN
  logic par;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) par <= 1'b0;
    else if (pop) par <= ^fifo_out;
  end
  always_comb
    txd = (state == START) ? 1'b0 : (state == DATA) ? shift[0] : (state == PARITY) ? par : 1'b1;
`else
  always_comb
    txd = (state == START) ? 1'b0 : (state == DATA) ? shift[0] : 1'b1;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud <= '0;
      bit_cnt <= '0;
      shift <= '0;
    end else begin
      baud <= (state == IDLE || wrap) ? '0 : baud + 1'b1;
      if (pop) begin
        shift <= fifo_out;
        bit_cnt <= '0;
      end else if (state == DATA && wrap) begin
        shift <= {1'b0, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end
  assign busy = state != IDLE || !empty;
  assign ctrl = {{(BITS-4){1'b0}}, PARITY_EN, overrun, busy, !full};
  assign bus.dataBusOut = bus.we ? '0 :
                          (bus.memAddr == BASE) ? BITS'(count) :
                          (bus.memAddr == CTRL_BASE) ? ctrl : '0;
endmodule

// File: tb/tb_uart_tx_device.sv
// tb_uart_tx_device: directed bench; written bytes go to a scoreboard, a txd frame decoder pops and compares them.
module tb_uart_tx_device;
  localparam int CPB = 4;
  localparam int DEP = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam logic [31:0] PB = 32'h8;
`else
  localparam int NB = 10;
  localparam logic [31:0] PB = 32'h0;
`endif
  localparam logic [31:0] BASE = 32'hF0000030;
  localparam logic [31:0] CBASE = 32'hF0000130;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic txd;
  always #5 clk = ~clk;
  uart_tx_device_if #(.BITS(32)) bus();
  uart_tx_device #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEP)) dut (
    .clk(clk),
    .reset(rst),
    .bus(bus.slave),
    .txd(txd)
  );
  int total = 0;
  int bad = 0;
  int ncyc = 0;
  int cyc = 0;
  int pos = -1;
  logic [7:0] sb[$];
  int starts[$];
  logic [7:0] rx;
`ifdef UART_TX_PARITY_EN
  logic par_bit;
`endif
  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Frame decoder: samples mid-bit on falling edges, aborts on reset.
  always @(negedge clk) begin
    int k;
    logic [7:0] e;
    cyc++;
    if (rst) pos = -1;
    else if (pos < 0) begin
      if (txd === 1'b0) begin
        pos = 0;
        starts.push_back(cyc);
      end
    end else pos++;
    if (pos >= 0 && pos % CPB == CPB / 2) begin
      k = pos / CPB;
      if (k == 0) check("start_bit", {31'b0, txd}, 32'h0);
      else if (k <= 8) rx[k-1] = txd;
`ifdef UART_TX_PARITY_EN
      else if (k < NB - 1) par_bit = txd;
`endif
      else begin
        check("stop_bit", {31'b0, txd}, 32'h1);
        check("frame_expected", 32'(sb.size() > 0), 32'h1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("rx_byte", {24'b0, rx}, {24'b0, e});
`ifdef UART_TX_PARITY_EN
          check("parity_bit", {31'b0, par_bit}, {31'b0, ^e});
`endif
        end
      end
    end
    if (pos == NB * CPB - 1) pos = -1;
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.we = 1'b1;
    bus.memAddr = a;
    bus.dataBusIn = d;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    bus.memAddr = 32'h100;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.we = 1'b0;
    bus.re = 1'b1;
    bus.memAddr = a;
    #1;
    d = bus.dataBusOut;
    bus.re = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] d;
    for (int i = 0; i < 1000; i++) begin
      rd(CBASE, d);
      if (d[1] == 1'b0 && sb.size() == 0) break;
      sync();
    end
    check({tag, "_busy_clear"}, {31'b0, d[1]}, 32'h0);
    check({tag, "_sb_drained"}, 32'(sb.size()), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    int w;
    bus.we = 1'b0;
    bus.re = 1'b0;
    bus.memAddr = 32'h100;
    bus.dataBusIn = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("txd_reset", {31'b0, txd}, 32'h1);
    rd(CBASE, d); check("ctrl_reset", d, 32'h1 | PB);
    rd(BASE, d); check("data_reset", d, 32'h0);
    rd(32'h100, d); check("unrelated_addr", d, 32'h0);
    bus.we = 1'b1; bus.memAddr = CBASE; bus.dataBusIn = 32'h4;
    #1;
    check("we_blocks_read", bus.dataBusOut, 32'h0);
    bus.we = 1'b0; bus.memAddr = 32'h100;
    sync();
    // single frame 0xA5, upper data bits ignored
    sb.push_back(8'hA5);
    wr(BASE, 32'hFFFFFFA5);
    check("latency_pre", {31'b0, txd}, 32'h1);
    rd(CBASE, d); check("ctrl_busy", d, 32'h3 | PB);
    sync();
    check("latency_fall", {31'b0, txd}, 32'h0);
    wait_idle("a5");
    rd(CBASE, d); check("ctrl_after_a5", d, 32'h1 | PB);
    // back-to-back 0x01..0x05
    sync();
    starts.delete();
    for (int i = 1; i <= 5; i++) begin
      sb.push_back(8'(i));
      wr(BASE, 32'(i));
    end
    rd(CBASE, d); check("ctrl_full", d, 32'h2 | PB);
    rd(BASE, d); check("count_full", d, 32'h4);
    wait_idle("b2b");
    check("b2b_frames", 32'(starts.size()), 32'h5);
    for (int i = 1; i < starts.size(); i++)
      check("b2b_gap", 32'(starts[i] - starts[i-1]), 32'(NB * CPB));
    // overrun while full, CTRL clear, push-when-full-with-pop
    sync();
    sb.push_back(8'h11);
    wr(BASE, 32'h11);
    w = ncyc;
    for (int i = 8'h12; i <= 8'h15; i++) begin
      sb.push_back(8'(i));
      wr(BASE, 32'(i));
    end
    wr(BASE, 32'h77);
    rd(CBASE, d); check("ctrl_overrun", d, 32'h6 | PB);
    sync();
    wr(CBASE, 32'h4);
    rd(CBASE, d); check("ctrl_keep_overrun", d, 32'h6 | PB);
    sync();
    wr(CBASE, 32'h0);
    rd(CBASE, d); check("ctrl_overrun_clr", d, 32'h2 | PB);
    while (ncyc < w + 40) sync();
    sb.push_back(8'h16);
    wr(BASE, 32'h16);
    rd(CBASE, d); check("push_with_pop", d, 32'h2 | PB);
    rd(BASE, d); check("count_push_pop", d, 32'h4);
    wait_idle("ovr");
    rd(CBASE, d); check("ctrl_after_ovr", d, 32'h1 | PB);
    // reset in the middle of a data bit
    sync();
    sb.push_back(8'h5A); wr(BASE, 32'h5A);
    sb.push_back(8'h5B); wr(BASE, 32'h5B);
    repeat (14) sync();
    rst = 1'b1;
    #1;
    check("txd_async_reset", {31'b0, txd}, 32'h1);
    sb.delete();
    rd(BASE, d); check("count_in_reset", d, 32'h0);
    rd(CBASE, d); check("ctrl_in_reset", d, 32'h1 | PB);
    sync();
    rst = 1'b0;
    sync();
    sb.push_back(8'h3C);
    wr(BASE, 32'h3C);
    wait_idle("post_rst");
`ifdef UART_TX_PARITY_EN
    sync();
    starts.delete();
    sb.push_back(8'h07); wr(BASE, 32'h07);
    sb.push_back(8'h03); wr(BASE, 32'h03);
    wait_idle("parity");
    check("parity_frames", 32'(starts.size()), 32'h2);
    if (starts.size() == 2) check("parity_len", 32'(starts[1] - starts[0]), 32'd44);
`endif
    repeat (4) sync();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
